// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard logic.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG       = 0;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } hz_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_src_match.sv
// Load-use source comparator: flags an IF/ID source that depends on a load in ID/EX.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  mem_read,
  output logic                  hit
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_nonzero = (rd != REG_ADDR_W'(ZERO_REG));
  assign rs1_match  = rs1_used && (rs1 == rd);
  assign rs2_match  = rs2_used && (rs2 == rd);
  assign hit        = mem_read && rd_nonzero && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit: load-use stalls, data-memory freeze, branch flush, stall counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_rs1_used,
  input  logic                  ifid_rs2_used,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  exmem_hold,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_STALL - 1);

  hz_state_t  state, state_d;
  hz_state_t  resume, resume_d;
  hz_state_t  eff_state;
  logic [3:0] cnt, cnt_d;
  logic       hit;
  logic       mem_wait;

  hazard_src_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_src_match (
    .rd       (idex_rd),
    .rs1      (ifid_rs1),
    .rs2      (ifid_rs2),
    .rs1_used (ifid_rs1_used),
    .rs2_used (ifid_rs2_used),
    .mem_read (idex_mem_read),
    .hit      (hit)
  );

  assign mem_wait = dmem_req && !dmem_ready;
  // The cycle that ends a memory wait behaves as a normal cycle of the interrupted state.
  assign eff_state = (state == MEM_WAIT) ? resume : state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      resume <= RUN;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      resume <= resume_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    resume_d    = resume;
    cnt_d       = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    exmem_hold  = 1'b0;
    if (mem_wait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      state_d    = MEM_WAIT;
      resume_d   = eff_state;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
    end else if (eff_state == LU_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cnt_d       = cnt - 4'd1;
      state_d     = (cnt == 4'd1) ? RUN : LU_STALL;
    end else begin
      state_d = RUN;
      if (hit) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (LOAD_USE_STALL > 1) begin
          cnt_d   = LU_RELOAD;
          state_d = LU_STALL;
        end
      end
    end
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      exmem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three parameterisations share one stimulus bus.
module tb_hazard_stall_ctrl;

  localparam logic [4:0] PASS   = 5'b11000;  // {pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold}
  localparam logic [4:0] STALL  = 5'b00100;
  localparam logic [4:0] FLUSH  = 5'b11110;
  localparam logic [4:0] FREEZE = 5'b00001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       idex_mem_read, ifid_rs1_used, ifid_rs2_used;
  logic       branch_taken, dmem_req, dmem_ready;

  logic        pw1, iw1, bb1, fl1, hd1;
  logic        pw2, iw2, bb2, fl2, hd2;
  logic        pw3, iw3, bb3, fl3, hd3;
  logic [15:0] sc1, sc2;
  logic [2:0]  sc3;
  logic [4:0]  o1, o2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALL(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs1_used(ifid_rs1_used),
    .ifid_rs2_used(ifid_rs2_used), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bb1),
    .ifid_flush(fl1), .exmem_hold(hd1), .stall_cycles(sc1));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALL(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs1_used(ifid_rs1_used),
    .ifid_rs2_used(ifid_rs2_used), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_write(pw2), .ifid_write(iw2), .idex_bubble(bb2),
    .ifid_flush(fl2), .exmem_hold(hd2), .stall_cycles(sc2));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALL(1), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_rs1_used(ifid_rs1_used),
    .ifid_rs2_used(ifid_rs2_used), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_write(pw3), .ifid_write(iw3), .idex_bubble(bb3),
    .ifid_flush(fl3), .exmem_hold(hd3), .stall_cycles(sc3));

  assign o1 = {pw1, iw1, bb1, fl1, hd1};
  assign o2 = {pw2, iw2, bb2, fl2, hd2};

  typedef struct {
    logic [4:0] rd;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic mr, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic rdy);
    idex_rd = rd; idex_mem_read = mr; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_rs1_used = u1; ifid_rs2_used = u2; branch_taken = br;
    dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw x5 in ID/EX, add reading x5 through rs2 in IF/ID
  task automatic load_use();
    drive(5'd5, 1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //         rd    mr    rs1   rs2   u1    u2    br    req   rdy   exp
    tv[0]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PASS};
    tv[1]  = '{5'd5, 1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    tv[2]  = '{5'd5, 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PASS};
    tv[3]  = '{5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PASS};
    tv[4]  = '{5'd7, 1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PASS};
    tv[5]  = '{5'd9, 1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    tv[6]  = '{5'd9, 1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FLUSH};
    tv[7]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, FLUSH};
    tv[8]  = '{5'd9, 1'b1, 5'd9, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, FREEZE};
    tv[9]  = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, PASS};
    tv[10] = '{5'd3, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, FREEZE};
    tv[11] = '{5'd12, 1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL};
    tv[12] = '{5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PASS};

    // Reset forces pass-through even with branch_taken and a hazard present
    reset = 1'b1;
    load_use();
    branch_taken = 1'b1;
    #2;
    chk("reset_outputs", o1, PASS);
    chk("reset_count", sc1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle-stall unit is stateless per cycle, so vectors are independent
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].rd, tv[i].mr, tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2,
            tv[i].br, tv[i].req, tv[i].rdy);
      #2;
      chk($sformatf("vec%0d", i), o1, tv[i].exp);
      @(negedge clk);
    end
    chk("vec_count", sc1, 5);

    // LOAD_USE_STALL 1 vs 2 on the same hazard; ID/EX becomes a bubble after the first cycle
    do_reset();
    load_use();
    #2; chk("lu1_c1", o1, STALL); chk("lu2_c1", o2, STALL);
    @(negedge clk);
    idex_mem_read = 1'b0;
    #2; chk("lu1_c2", o1, PASS); chk("lu2_c2", o2, STALL);
    @(negedge clk);
    idle();
    #2; chk("lu1_c3", o1, PASS); chk("lu2_c3", o2, PASS);
    @(negedge clk);
    chk("lu1_count", sc1, 1);
    chk("lu2_count", sc2, 2);

    // Memory wait on the second stall cycle preserves the remaining bubble
    do_reset();
    load_use();
    #2; chk("mw_c1", o2, STALL);
    @(negedge clk);
    idle();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2; chk($sformatf("mw_freeze%0d", i), o2, FREEZE);
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #2; chk("mw_resume", o2, STALL);
    @(negedge clk);
    idle();
    #2; chk("mw_run", o2, PASS);
    @(negedge clk);
    chk("mw_count", sc2, 5);

    // Branch cancels a pending stall, then a branch in RUN leaves the counter alone
    do_reset();
    load_use();
    #2; chk("br_c1", o2, STALL);
    @(negedge clk);
    branch_taken = 1'b1;
    #2; chk("br_cancel", o2, FLUSH);
    @(negedge clk);
    idle();
    #2; chk("br_after", o2, PASS);
    @(negedge clk);
    chk("br_count1", sc2, 1);
    branch_taken = 1'b1;
    #2; chk("br_run", o2, FLUSH);
    @(negedge clk);
    idle();
    chk("br_count2", sc2, 1);

    // Asynchronous reset in the middle of LU_STALL
    do_reset();
    load_use();
    #2; chk("rs_c1", o2, STALL);
    @(negedge clk);
    #2; chk("rs_c2", o2, STALL); chk("rs_cnt_pre", sc2, 1);
    #1; reset = 1'b1; branch_taken = 1'b1;
    #1; chk("rs_async_out", o2, PASS); chk("rs_async_cnt", sc2, 0);
    @(negedge clk);
    reset = 1'b0; branch_taken = 1'b0;
    #2; chk("rs_fresh1", o2, STALL);
    @(negedge clk);
    idex_mem_read = 1'b0;
    #2; chk("rs_fresh2", o2, STALL);
    @(negedge clk);
    #2; chk("rs_fresh3", o2, PASS);
    @(negedge clk);
    chk("rs_count", sc2, 2);

    // Nine frozen cycles saturate the 3-bit counter
    do_reset();
    dmem_req = 1'b1;
    repeat (9) @(negedge clk);
    idle();
    #2;
    chk("sat_cnt3", sc3, 7);
    chk("sat_cnt16", sc1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
